// File: rtl/aes_pkg.sv
// Shared AES definitions: sizes, word/round-key types, xtime and the S-box
// used by both the key schedule and the cipher SubBytes stage.
package aes_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef logic [31:0]            word_t;
    typedef logic [AES_KEY_W-1:0]   rkey_t;

    // S-box rows 0x00..0xF0, entry 0x00 in the most significant byte
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_FLAT[{(8'hff - b), 3'b000} +: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One AES-128 key-expansion round, purely combinational.
// Word 0 is the most significant 32 bits of the round key.
module aes128_key_step
    import aes_pkg::*;
(
    input  rkey_t       i_key,
    input  logic [7:0]  i_rcon,
    output rkey_t       o_key
);

    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_rot, w_sub;
    word_t w_n0, w_n1, w_n2, w_n3;

    assign w_w0  = i_key[127:96];
    assign w_w1  = i_key[95:64];
    assign w_w2  = i_key[63:32];
    assign w_w3  = i_key[31:0];

    // RotWord moves the leading byte to the end before substitution
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    assign w_sub = sub_word(w_rot);

    assign w_n0  = w_w0 ^ w_sub ^ {i_rcon, 24'h000000};
    assign w_n1  = w_w1 ^ w_n0;
    assign w_n2  = w_w2 ^ w_n1;
    assign w_n3  = w_w3 ^ w_n2;

    assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes128_key_schedule_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into round keys
// 0..10 (one round per clock), stores them and serves them through a
// registered read port. Optional build macro KEYSCHED_ZEROIZE_EN adds a
// zeroize input that synchronously wipes all key material.
module aes128_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = AES_NR,
    parameter int KEY_W = AES_KEY_W
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rk_rd_idx,
    output logic [KEY_W-1:0] rk_rd_data,
    output logic             rk_rd_valid
`ifdef KEYSCHED_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    generate
        if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
            $error("aes128_key_schedule_ctrl supports only NR=10, KEY_W=128");
        end
    endgenerate

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EXP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [3:0]         r_round;
    logic [7:0]         r_rcon;
    rkey_t              r_last;              // latched key, then most recent round key
    rkey_t              r_rk [AES_NR+1];
    logic [AES_NR:0]    r_mask;
    logic               r_busy;
    logic               r_done;
    logic               r_keys_valid;
    rkey_t              r_rd_data;
    logic               r_rd_valid;

    rkey_t              w_next;
    logic               w_zeroize;
    logic [15:0]        w_mask16;
    logic               w_rd_hit;

`ifdef KEYSCHED_ZEROIZE_EN
    assign w_zeroize = zeroize;
`else
    assign w_zeroize = 1'b0;
`endif

    aes128_key_step u_step (
        .i_key  (r_last),
        .i_rcon (r_rcon),
        .o_key  (w_next)
    );

    // Controller: FSM, round counter, rcon and key storage advance together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_round      <= 4'd0;
            r_rcon       <= 8'h01;
            r_last       <= '0;
            r_mask       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i <= AES_NR; i++) r_rk[i] <= '0;
        end else if (w_zeroize) begin
            r_state      <= S_IDLE;
            r_round      <= 4'd0;
            r_rcon       <= 8'h01;
            r_last       <= '0;
            r_mask       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_keys_valid <= 1'b0;
            for (int i = 0; i <= AES_NR; i++) r_rk[i] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last  <= key_in;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // The previous key set stops being visible from here on
                    r_rk[0]      <= r_last;
                    r_mask       <= {{AES_NR{1'b0}}, 1'b1};
                    r_keys_valid <= 1'b0;
                    r_rcon       <= 8'h01;
                    r_round      <= 4'd1;
                    r_state      <= S_EXP;
                end
                S_EXP: begin
                    r_rk[r_round]   <= w_next;
                    r_last          <= w_next;
                    r_mask[r_round] <= 1'b1;
                    r_rcon          <= xtime(r_rcon);
                    if (r_round == 4'(NR)) begin
                        r_state <= S_DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                default: begin
                    r_done       <= 1'b1;
                    r_keys_valid <= 1'b1;
                    r_busy       <= 1'b0;
                    r_round      <= 4'd0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign w_mask16 = {{(15 - AES_NR){1'b0}}, r_mask};
    assign w_rd_hit = (rk_rd_idx <= 4'(NR)) && w_mask16[rk_rd_idx];

    // Registered read port: unwritten or out-of-range indices return zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_zeroize) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_data  <= w_rd_hit ? r_rk[rk_rd_idx] : '0;
            r_rd_valid <= w_rd_hit;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign keys_valid  = r_keys_valid;
    assign rk_rd_data  = r_rd_data;
    assign rk_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Bench for aes128_key_schedule_ctrl: FIPS-197 A.1 vectors, rcon sequence,
// read-port polling during expansion, restart/abort behaviour and, when
// KEYSCHED_ZEROIZE_EN is defined, zeroize.
module tb_aes128_key_schedule_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, keys_valid;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         zeroize;
`endif

    aes128_key_schedule_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid)
`ifdef KEYSCHED_ZEROIZE_EN
        ,
        .zeroize     (zeroize)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         v;
        logic [127:0] d;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int      n_vec = 0;
    int      n_bad = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    logic [127:0] fips_rk [11];
    logic [7:0]   rcon_exp [10];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_chk(input string tag);
        rd_exp_t e;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: scoreboard empty, got valid=%0d", tag, rk_rd_valid);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 128'(rk_rd_valid), 128'(e.v));
            chk({tag, "_data"}, rk_rd_data, e.d);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge after the check
    task automatic rd_chk(input logic [3:0] idx, input logic v, input logic [127:0] d);
        rd_exp_t e;
        rk_rd_idx = idx;
        e.v = v;
        e.d = d;
        sb_q.push_back(e);
        @(negedge clk);
        sb_pop_chk($sformatf("rd%0d", idx));
    endtask

    task automatic pulse_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) chk("done_timeout", 128'(done), 128'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_exp_t e;
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        rcon_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

        reset = 1'b1;
        start = 1'b0;
        key_in = '0;
        rk_rd_idx = 4'd0;
`ifdef KEYSCHED_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_kv", 128'(keys_valid), 128'd0);
        chk("rst_rdv", 128'(rk_rd_valid), 128'd0);
        chk("rst_rdd", rk_rd_data, 128'd0);
        chk("rst_rcon", 128'(dut.r_rcon), 128'h01);

        // FIPS key with idx 5 polled throughout; c is the edge index (start edge = 0)
        start = 1'b1;
        key_in = FIPS_KEY;
        rk_rd_idx = 4'd5;
        e.v = 1'b0;
        e.d = '0;
        sb_q.push_back(e);
        for (int c = 0; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            sb_pop_chk($sformatf("poll5_c%0d", c));
            if (c < 13) begin
                e.v = (c + 1 >= 7);
                e.d = (c + 1 >= 7) ? fips_rk[5] : '0;
                sb_q.push_back(e);
            end
            chk($sformatf("busy_c%0d", c), 128'(busy), 128'(c <= 11));
            chk($sformatf("done_c%0d", c), 128'(done), 128'(c == 12));
            if (c >= 1 && c <= 10)
                chk($sformatf("rcon_r%0d", c), 128'(dut.r_rcon), 128'(rcon_exp[c-1]));
            if (c >= 1 && c <= 11)
                chk($sformatf("kv_c%0d", c), 128'(keys_valid), 128'd0);
        end
        chk("kv_after", 128'(keys_valid), 128'd1);
        for (int i = 0; i <= 10; i++) rd_chk(4'(i), 1'b1, fips_rk[i]);
        rd_chk(4'd12, 1'b0, '0);
        rd_chk(4'd15, 1'b0, '0);

        // Restart over a valid set, with a stray start (key 0) at edge 4
        start = 1'b1;
        key_in = FIPS_KEY;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 3);
            key_in = (c == 3) ? 128'd0 : FIPS_KEY;
            chk($sformatf("rs_done_c%0d", c), 128'(done), 128'(c == 12));
            if (c >= 1 && c <= 11)
                chk($sformatf("rs_kv_c%0d", c), 128'(keys_valid), 128'd0);
        end
        start = 1'b0;
        for (int i = 0; i <= 10; i++) rd_chk(4'(i), 1'b1, fips_rk[i]);

        // Abort with reset in cycle 6, then expand the all-zero key
        pulse_start(FIPS_KEY);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_kv", 128'(keys_valid), 128'd0);
        chk("abort_rdv", 128'(rk_rd_valid), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        rd_chk(4'd0, 1'b0, '0);
        pulse_start(128'd0);
        wait_done(20);
        @(negedge clk);
        chk("zk_kv", 128'(keys_valid), 128'd1);
        rd_chk(4'd0, 1'b1, 128'd0);
        rd_chk(4'd1, 1'b1, 128'h62636363626363636263636362636363);
        rd_chk(4'd10, 1'b1, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

`ifdef KEYSCHED_ZEROIZE_EN
        // Zeroize wipes the stored set
        zeroize = 1'b1;
        @(negedge clk);
        zeroize = 1'b0;
        chk("zz_kv", 128'(keys_valid), 128'd0);
        for (int i = 0; i <= 10; i++) rd_chk(4'(i), 1'b0, '0);
        // Zeroize beats a simultaneous start
        start = 1'b1;
        zeroize = 1'b1;
        key_in = FIPS_KEY;
        @(negedge clk);
        start = 1'b0;
        zeroize = 1'b0;
        chk("zz_start_busy", 128'(busy), 128'd0);
        repeat (14) @(negedge clk);
        chk("zz_start_kv", 128'(keys_valid), 128'd0);
        rd_chk(4'd0, 1'b0, '0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
